// File: rtl/cycle_pkg.sv
// Shared encodings for the instruction-cycle sequencer: subcycle phases and
// control FSM states.
package cycle_pkg;

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    typedef enum logic [1:0] {
        ST_PARK = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

endpackage

// File: rtl/cycle_seq_step_edge.sv
// Two-flop synchronizer plus rising-edge detect for an asynchronous,
// already-debounced button; pulse is high for one clk per press.
module step_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic meta;
    logic synced;
    logic synced_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta        <= 1'b0;
            synced      <= 1'b0;
            synced_prev <= 1'b0;
        end else begin
            meta        <= din;
            synced      <= meta;
            synced_prev <= synced;
        end
    end

    assign pulse = synced & ~synced_prev;

endmodule

// File: rtl/cycle_seq.sv
// Instruction-cycle sequencer: turns divider ticks into the eight subcycles
// A1..X3, with free-run and single-instruction-cycle step modes.
module cycle_seq
    import cycle_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             run_mode,
    input  logic             step_req,
    output logic [2:0]       phase,
    output logic [7:0]       phase_oh,
    output logic             sync,
    output logic             sub_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             parked
);

    state_t     state;
    state_t     state_nxt;
    logic       step_pulse;
    logic       adv;
    logic       wrap;

    step_edge u_step_edge (
        .clk   (clk),
        .rst   (rst),
        .din   (step_req),
        .pulse (step_pulse)
    );

    // Mode changes are only honoured at the X3->A1 boundary; step edges seen
    // outside PARK are dropped rather than queued.
    always_comb begin
        state_nxt = state;
        adv       = 1'b0;
        wrap      = 1'b0;
        case (state)
            ST_PARK: begin
                if (run_mode) begin
                    state_nxt = ST_RUN;
                end else if (step_pulse) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_RUN: begin
                adv  = tick;
                wrap = tick && (phase == PH_X3);
                if (wrap && !run_mode) begin
                    state_nxt = ST_PARK;
                end
            end
            ST_STEP: begin
                adv  = tick;
                wrap = tick && (phase == PH_X3);
                if (wrap) begin
                    state_nxt = run_mode ? ST_RUN : ST_PARK;
                end
            end
            default: state_nxt = ST_PARK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_PARK;
            phase     <= PH_A1;
            sub_en    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state  <= state_nxt;
            sub_en <= adv;
            if (adv) begin
                phase <= phase + 3'd1;
            end
            if (wrap) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

    // Pure decodes of registered state, so no added latency or glitches.
    assign phase_oh = 8'b1 << phase;
    assign sync     = (phase == PH_X3);
    assign parked   = (state == ST_PARK);

endmodule
